// File: rtl/wb_pkg.sv
// Shared parameters, requester indices and slot state encoding for the write-back port arbiter.
package wb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_M = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry holding slot with valid/ready intake; writes to register 0 are accepted and dropped.
// Latency: one edge to FULL. Ready while empty or being drained by a grant this cycle.
module wb_slot
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              val,
    input  logic [ADDR_W-1:0] dir,
    input  logic [DATA_W-1:0] data,
    input  logic              grant,
    output logic              rdy,
    output logic              full,
    output logic [ADDR_W-1:0] q_dir,
    output logic [DATA_W-1:0] q_data
);

    slot_state_t state, state_nxt;
    logic        load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        rdy       = (state == SLOT_EMPTY) | grant;
        load      = val & rdy;
        state_nxt = state;
        if (load) begin
            // Register 0 is hardwired; the handshake completes but nothing is held.
            state_nxt = (dir != '0) ? SLOT_FULL : SLOT_EMPTY;
        end else if (grant) begin
            state_nxt = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_dir  <= '0;
            q_data <= '0;
        end else if (load) begin
            q_dir  <= dir;
            q_data <= data;
        end
    end

    assign full = (state == SLOT_FULL);

endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin share of the register-bank write port between ALU (A) and load (M) paths.
// Latency: 2 edges requester-to-bank; a slot is ready when empty or granted this cycle.
// Optional WB_PENDING_EN builds the per-register pending-write mask on Pend.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              A_Val,
    input  logic [ADDR_W-1:0] A_Dir,
    input  logic [DATA_W-1:0] A_Data,
    output logic              A_Rdy,
    input  logic              M_Val,
    input  logic [ADDR_W-1:0] M_Dir,
    input  logic [DATA_W-1:0] M_Data,
    output logic              M_Rdy,
    output logic              Rw,
    output logic [ADDR_W-1:0] Dir,
    output logic [DATA_W-1:0] DIn,
    output logic [31:0]       Pend
);

    logic              a_full, m_full;
    logic [ADDR_W-1:0] a_dir, m_dir;
    logic [DATA_W-1:0] a_data, m_data;
    logic              grant_a, grant_m;
    logic              ptr, ptr_nxt;
    logic              a_owed, a_owed_nxt;

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_a (
        .clk    (clk),
        .reset  (reset),
        .val    (A_Val),
        .dir    (A_Dir),
        .data   (A_Data),
        .grant  (grant_a),
        .rdy    (A_Rdy),
        .full   (a_full),
        .q_dir  (a_dir),
        .q_data (a_data)
    );

    wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_m (
        .clk    (clk),
        .reset  (reset),
        .val    (M_Val),
        .dir    (M_Dir),
        .data   (M_Data),
        .grant  (grant_m),
        .rdy    (M_Rdy),
        .full   (m_full),
        .q_dir  (m_dir),
        .q_data (m_data)
    );

    // Same-register contention lets the older load land first and forces the
    // ALU value through on the following cycle without moving the pointer.
    always_comb begin
        grant_a    = 1'b0;
        grant_m    = 1'b0;
        ptr_nxt    = ptr;
        a_owed_nxt = 1'b0;
        if (a_full && m_full) begin
            if (a_owed) begin
                grant_a = 1'b1;
            end else if (a_dir == m_dir) begin
                grant_m    = 1'b1;
                a_owed_nxt = 1'b1;
            end else if (ptr == REQ_A) begin
                grant_a = 1'b1;
                ptr_nxt = REQ_M;
            end else begin
                grant_m = 1'b1;
                ptr_nxt = REQ_A;
            end
        end else if (a_full) begin
            grant_a = 1'b1;
        end else if (m_full) begin
            grant_m = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= REQ_A;
            a_owed <= 1'b0;
            Rw     <= 1'b0;
            Dir    <= '0;
            DIn    <= '0;
        end else begin
            ptr    <= ptr_nxt;
            a_owed <= a_owed_nxt;
            Rw     <= grant_a | grant_m;
            if (grant_a) begin
                Dir <= a_dir;
                DIn <= a_data;
            end else if (grant_m) begin
                Dir <= m_dir;
                DIn <= m_data;
            end
        end
    end

`ifdef WB_PENDING_EN
    always_comb begin
        Pend = '0;
        for (int r = 1; r < 32; r++) begin
            Pend[r] = (a_full && (a_dir == ADDR_W'(r))) ||
                      (m_full && (m_dir == ADDR_W'(r))) ||
                      (Rw && (Dir == ADDR_W'(r)));
        end
    end
`else
    assign Pend = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed test-plan cases plus randomized traffic
// compared every cycle against a behavioural slot/arbiter model and a no-loss scoreboard.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          A_Val, M_Val, A_Rdy, M_Rdy, Rw;
    logic [AW-1:0] A_Dir, M_Dir, Dir;
    logic [DW-1:0] A_Data, M_Data, DIn;
    logic [31:0]   Pend;

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .A_Val(A_Val), .A_Dir(A_Dir), .A_Data(A_Data), .A_Rdy(A_Rdy),
        .M_Val(M_Val), .M_Dir(M_Dir), .M_Data(M_Data), .M_Rdy(M_Rdy),
        .Rw(Rw), .Dir(Dir), .DIn(DIn), .Pend(Pend)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pexp(input logic [31:0] m);
`ifdef WB_PENDING_EN
        return m;
`else
        return 32'h0 & m;
`endif
    endfunction

    // Behavioural model: contents of each slot, who goes next, expected bank port.
    logic          mf[2];
    logic [AW-1:0] md[2];
    logic [DW-1:0] mdat[2];
    int            mptr;
    bit            mowe;
    logic          er;
    logic [AW-1:0] ed;
    logic [DW-1:0] edin;
    logic [AW+DW-1:0] q_a[$];
    logic [AW+DW-1:0] q_m[$];

    function automatic int winner();
        if (mf[0] && mf[1]) begin
            if (mowe) return 0;
            if (md[0] == md[1]) return 1;
            return mptr;
        end
        if (mf[0]) return 0;
        if (mf[1]) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] pend_model();
        logic [31:0] p;
        p = 32'h0;
        for (int i = 0; i < 2; i++)
            if (mf[i]) p[md[i]] = 1'b1;
        if (er) p[ed] = 1'b1;
        p[0] = 1'b0;
        return pexp(p);
    endfunction

    always @(posedge clk) begin
        int            w;
        logic          vin[2];
        logic [AW-1:0] din_dir[2];
        logic [DW-1:0] din_dat[2];
        logic          rdy[2];
        bit            both_diff;
        vin[0] = A_Val; din_dir[0] = A_Dir; din_dat[0] = A_Data;
        vin[1] = M_Val; din_dir[1] = M_Dir; din_dat[1] = M_Data;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin mf[i] = 1'b0; md[i] = '0; mdat[i] = '0; end
            mptr = 0; mowe = 1'b0; er = 1'b0; ed = '0; edin = '0;
            q_a.delete(); q_m.delete();
        end else begin
            w = winner();
            rdy[0] = !mf[0] || (w == 0);
            rdy[1] = !mf[1] || (w == 1);
            er = (w >= 0);
            if (w >= 0) begin ed = md[w]; edin = mdat[w]; end
            both_diff = mf[0] && mf[1] && !mowe && (md[0] != md[1]);
            mowe = mf[0] && mf[1] && !mowe && (md[0] == md[1]);
            if (both_diff) mptr = 1 - mptr;
            for (int i = 0; i < 2; i++) begin
                if (w == i) mf[i] = 1'b0;
                if (vin[i] && rdy[i] && din_dir[i] != '0) begin
                    mf[i] = 1'b1; md[i] = din_dir[i]; mdat[i] = din_dat[i];
                    if (i == 0) q_a.push_back({din_dir[i], din_dat[i]});
                    else        q_m.push_back({din_dir[i], din_dat[i]});
                end
            end
        end
    end

    always @(negedge clk) begin
        int w;
        logic [AW+DW-1:0] wr;
        if (chk_on) begin
            w = winner();
            chk("a_rdy", 32'(A_Rdy), 32'(!mf[0] || w == 0));
            chk("m_rdy", 32'(M_Rdy), 32'(!mf[1] || w == 1));
            chk("rw", 32'(Rw), 32'(er));
            chk("dir", 32'(Dir), 32'(ed));
            chk("din", DIn, edin);
            chk("pend", Pend, pend_model());
            if (Rw === 1'b1) begin
                wr = {Dir, DIn};
                n_chk++;
                if (q_a.size() > 0 && q_a[0] == wr) void'(q_a.pop_front());
                else if (q_m.size() > 0 && q_m[0] == wr) void'(q_m.pop_front());
                else begin
                    n_fail++;
                    $display("FAIL sb_write: got dir %0d data %h, not at head of A or M queue", Dir, DIn);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        A_Val = 1'b0; M_Val = 1'b0;
    endtask

    task automatic put(input logic av, input logic [AW-1:0] ad, input logic [DW-1:0] adat,
                       input logic mv, input logic [AW-1:0] mdr, input logic [DW-1:0] mdt);
        A_Val = av; A_Dir = ad; A_Data = adat;
        M_Val = mv; M_Dir = mdr; M_Data = mdt;
    endtask

    initial begin
        reset = 1'b1;
        put(0, 0, 0, 0, 0, 0);
        tick();
        chk_on = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_rw", 32'(Rw), 0);
        chk("rst_dir", 32'(Dir), 0);
        chk("rst_din", DIn, 0);
        chk("rst_ardy", 32'(A_Rdy), 1);
        chk("rst_mrdy", 32'(M_Rdy), 1);
        chk("rst_pend", Pend, 0);

        // Single write, 2-edge latency
        put(1, 5, 32'h0000ABCD, 0, 0, 0);
        tick(); idle();
        chk("sw_rw_e1", 32'(Rw), 0);
        chk("sw_pend_e1", Pend, pexp(32'h20));
        tick();
        chk("sw_rw_e2", 32'(Rw), 1);
        chk("sw_dir_e2", 32'(Dir), 5);
        chk("sw_din_e2", DIn, 32'h0000ABCD);
        tick();
        chk("sw_rw_e3", 32'(Rw), 0);
        chk("sw_pend_e3", Pend, 0);

        // Contention, different Dir: A first, then M; next contention M first
        put(1, 3, 32'h11, 1, 4, 32'h22);
        tick(); idle();
        tick();
        chk("c1_dir_a", 32'(Dir), 3); chk("c1_din_a", DIn, 32'h11);
        tick();
        chk("c1_dir_m", 32'(Dir), 4); chk("c1_din_m", DIn, 32'h22);
        tick();
        put(1, 8, 32'h33, 1, 9, 32'h44);
        tick(); idle();
        tick();
        chk("c2_dir_m", 32'(Dir), 9); chk("c2_din_m", DIn, 32'h44);
        tick();
        chk("c2_dir_a", 32'(Dir), 8); chk("c2_din_a", DIn, 32'h33);
        tick();

        // Same Dir: M value lands first, ALU value last, pointer left on A
        put(1, 7, 32'hAA, 1, 7, 32'hBB);
        tick(); idle();
        chk("sd_pend", Pend, pexp(32'h80));
        tick();
        chk("sd_dir1", 32'(Dir), 7); chk("sd_din1", DIn, 32'hBB);
        tick();
        chk("sd_rw2", 32'(Rw), 1); chk("sd_din2", DIn, 32'hAA);
        tick();
        put(1, 10, 32'h1, 1, 11, 32'h2);
        tick(); idle();
        tick();
        chk("sd_ptr_dir", 32'(Dir), 10);
        tick(); tick();

        // Register-0 write is accepted and dropped
        put(0, 0, 0, 1, 0, 32'hFFFF);
        chk("z_mrdy", 32'(M_Rdy), 1);
        tick(); idle();
        chk("z_rw1", 32'(Rw), 0); chk("z_pend", Pend, 0); chk("z_mrdy2", 32'(M_Rdy), 1);
        tick();
        chk("z_rw2", 32'(Rw), 0);

        // Reset mid-operation
        put(1, 12, 32'hC, 1, 13, 32'hD);
        tick(); idle();
        reset = 1'b1;
        tick();
        chk("mr_rw1", 32'(Rw), 0); chk("mr_ardy", 32'(A_Rdy), 1);
        chk("mr_mrdy", 32'(M_Rdy), 1); chk("mr_pend", Pend, 0);
        reset = 1'b0;
        tick();
        chk("mr_rw2", 32'(Rw), 0);
        put(1, 14, 32'h77, 0, 0, 0);
        tick(); idle();
        chk("mr_rw3", 32'(Rw), 0);
        tick();
        chk("mr_rw4", 32'(Rw), 1); chk("mr_dir4", 32'(Dir), 14); chk("mr_din4", DIn, 32'h77);
        tick();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            reset  = ($urandom_range(0, 199) == 0);
            A_Val  = 1'($urandom_range(0, 1));
            M_Val  = 1'($urandom_range(0, 1));
            A_Dir  = AW'($urandom_range(0, 7));
            M_Dir  = AW'($urandom_range(0, 7));
            A_Data = $urandom;
            M_Data = $urandom;
            tick();
        end
        reset = 1'b0;
        idle();
        repeat (4) tick();
        chk("drain_a", 32'(q_a.size()), 0);
        chk("drain_m", 32'(q_m.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-bank write port (Rw/Dir/DIn) between two write-back requesters: ALU result path (A) and memory-load path (M).
- Each requester has a valid/ready handshake into a 1-entry holding slot; a round-robin arbiter drains slots into a registered write-port stage.
- Sits between the execute/memory stages and the 32x32 register bank; outputs connect directly to the bank's Rw, Dir and DIn inputs.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- A_Val  in  1  ALU requester has a write.
- A_Dir  in  ADDR_W  ALU destination register.
- A_Data  in  DATA_W  ALU write data.
- A_Rdy  out  1  ALU slot can accept this cycle.
- M_Val  in  1  memory requester has a write.
- M_Dir  in  ADDR_W  memory destination register.
- M_Data  in  DATA_W  memory write data.
- M_Rdy  out  1  memory slot can accept this cycle.
- Rw  out  1  write enable to register bank (registered, one-cycle pulse per write).
- Dir  out  ADDR_W  write address to bank (registered).
- DIn  out  DATA_W  write data to bank (registered).
- Pend  out  32  per-register pending-write mask (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): both slots empty, Rw=0, Dir=0, DIn=0, round-robin pointer = A preferred, Pend=0. Reset mid-operation discards buffered writes; no Rw pulse occurs in the reset cycle or the cycle after it.
- Slot: states EMPTY/FULL. Transfer happens when X_Val & X_Rdy at the clock edge.
- X_Rdy = slot EMPTY | slot granted this cycle. Grant depends only on registered slot state, so there is no Val->Rdy combinational path.
- Register-0 writes: a transfer with X_Dir==0 completes the handshake but is discarded. The slot stays or becomes EMPTY and Rw is never asserted for Dir 0.
- Arbitration each cycle among FULL slots:
  - Only one FULL: that slot is granted.
  - Both FULL with different Dir: the pointer side wins; the pointer then flips to the other side.
  - Both FULL with equal Dir: M wins (it is the older instruction), the pointer is unchanged, and A is granted next cycle so the ALU value lands last.
- Grant edge: the winner's Dir/Data are registered into Dir/DIn with Rw=1; the winner's slot empties unless refilled on the same edge.
- No FULL slot: Rw=0 next cycle; Dir/DIn hold their last values.
- Latency: transfer at edge N -> slot FULL; Rw=1 visible after edge N+1 if uncontested. Requester-to-bank latency is 2 edges.
- Throughput: one bank write per cycle total. An uncontested requester sustains 1 transfer/cycle; under contention each requester gets 1 per 2 cycles.
- No write is ever dropped except Dir==0 writes and writes lost to reset.

Optional Feature:
- Macro WB_PENDING_EN.
- Defined: Pend[r]=1 while any FULL slot or the output stage (Rw=1) targets register r; Pend[0] is always 0. The mask is combinational from registered state, for the hazard/stall unit.
- Not defined: Pend tied to 0 and no tracking logic is generated.

Decomposition:
- Package wb_pkg holds:
  - DATA_W/ADDR_W defaults.
  - Requester index constants REQ_A=0, REQ_M=1.
  - Slot state encoding SLOT_EMPTY=0, SLOT_FULL=1.
- Sub-module wb_slot (1-entry holding register with Val/Rdy, Dir-0 discard, grant-drain), instantiated twice.
- The arbiter and output register stay in the top module.

Test Plan:
- Reset then idle -> Rw=0, Dir=0, DIn=0, A_Rdy=M_Rdy=1, Pend=0.
- Single write: A_Val=1, A_Dir=5, A_Data=0x0000ABCD at edge 1 -> Rw=1, Dir=5, DIn=0x0000ABCD after edge 2; Rw=0 after edge 3.
- Contention, different Dir: A(Dir 3, 0x11) and M(Dir 4, 0x22) transfer at the same edge -> writes Dir 3 then Dir 4 on consecutive cycles; the next contention grants M first.
- Same-Dir ordering: A(Dir 7, 0xAA) and M(Dir 7, 0xBB) at the same edge -> Dir 7 written 0xBB, then 0xAA; pointer unchanged.
- Dir 0 discard: M_Val=1, M_Dir=0, M_Data=0xFFFF -> handshake completes, Rw stays 0; with WB_PENDING_EN defined, Pend stays 0.
- Reset mid-operation: both slots FULL, reset asserted for one edge -> no Rw pulse; slots EMPTY; a new A write afterward is written normally with 2-edge latency.
